// File: rtl/ps2_receiver.sv
// ps2_receiver: recovers bytes from raw PS/2 keyboard clock/data pins.
// Synchronises both pins, glitch-filters the clock, deframes the 11-bit
// frame (start, 8 data LSB first, odd parity, stop), and aborts stalled
// frames after TIMEOUT clk cycles without a falling edge.
//
// Ports:
//   clk      system clock
//   reset    asynchronous, active-high reset
//   ps2_clk  raw PS/2 clock pin (idle high)
//   ps2_data raw PS/2 data pin (idle high)
//   data     last correctly received byte, held between frames
//   valid    one-cycle pulse, data carries the new byte in the same cycle
//   error    one-cycle pulse on parity error, stop-bit error or timeout
//   busy     high while a frame is in progress
module ps2_receiver #(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       valid,
  output logic       error,
  output logic       busy
);

  localparam int unsigned TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned SHIFT_W = 10;

  typedef enum logic {IDLE, RECV} state_t;

  logic                  clk_s1, clk_s2;
  logic                  data_s1, data_s2;
  logic [FILTER_LEN-1:0] filt_sr;
  logic                  clk_f, clk_f_d;
  logic                  fe;

  state_t                state_q, state_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [SHIFT_W-1:0]    shift_q, shift_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic [7:0]            data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  error_q, error_d;
  logic                  busy_q, busy_d;

  // Pin synchronisers, clock filter and edge-detect history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
      filt_sr <= '1;
      clk_f   <= 1'b1;
      clk_f_d <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
      filt_sr <= {filt_sr[FILTER_LEN-2:0], clk_s2};
      // Level only changes on a full run of identical samples
      if (~|filt_sr)
        clk_f <= 1'b0;
      else if (&filt_sr)
        clk_f <= 1'b1;
      clk_f_d <= clk_f;
    end
  end

  assign fe = ~clk_f & clk_f_d;

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      to_cnt_q  <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      to_cnt_q  <= to_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    to_cnt_d  = to_cnt_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    error_d   = 1'b0;

    case (state_q)
      IDLE: begin
        to_cnt_d = '0;
        if (fe && !data_s2) begin
          state_d   = RECV;
          bit_cnt_d = 4'd1;
        end
      end

      RECV: begin
        if (fe) begin
          // New bits enter at the MSB so bit 1 ends up in shift[0]
          shift_d   = {data_s2, shift_q[SHIFT_W-1:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          to_cnt_d  = '0;
          if (bit_cnt_q == 4'd10) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            if ((^shift_d[8:0]) && shift_d[9]) begin
              data_d  = shift_d[7:0];
              valid_d = 1'b1;
            end else begin
              error_d = 1'b1;
            end
          end
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          to_cnt_d  = '0;
          error_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RECV);
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign error = error_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_ps2_receiver.sv
// tb_ps2_receiver: directed-vector bench for ps2_receiver. Drives PS/2
// frames bit by bit, records every valid/error pulse, and compares against
// hand-computed bytes and pulse counts.
module tb_ps2_receiver;

  localparam int unsigned FILTER_LEN = 8;
  localparam int unsigned TIMEOUT    = 2000;
  localparam int          HALF       = 40;

  logic       clk;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] data;
  logic       valid;
  logic       error;
  logic       busy;

  int n_checks;
  int n_errors;
  int n_valid;
  int n_err;
  int n_both;
  int n_busy_at_valid;
  logic [7:0] rx[$];

  ps2_receiver #(
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .data    (data),
    .valid   (valid),
    .error   (error),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (valid) begin
      n_valid++;
      rx.push_back(data);
      if (busy) n_busy_at_valid++;
    end
    if (error) n_err++;
    if (valid && error) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // {stop, parity, data, start}; good_par selects odd or deliberately wrong parity
  function automatic logic [10:0] make_frame(input logic [7:0] d, input logic good_par,
                                             input logic stop);
    logic par;
    par = good_par ? ~(^d) : (^d);
    return {stop, par, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      ps2_data = f[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [10:0] f);
    send_bits(f, 0, 10);
    ps2_data = 1'b1;
  endtask

  function automatic logic [31:0] rx_at(input int i);
    if (i < rx.size()) return 32'(rx[i]);
    return 32'hFFFF;
  endfunction

  // Hard stop so the bench can never hang
  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v0, e0, q0;
    logic [10:0] f;
    logic busy_seen;

    n_checks = 0; n_errors = 0; n_valid = 0; n_err = 0; n_both = 0; n_busy_at_valid = 0;
    ps2_clk = 1'b1; ps2_data = 1'b1; reset = 1'b1;
    wait_cyc(4);
    check("rst_data", 32'(data), 32'h00);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_error", 32'(error), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    wait_cyc(20);

    // Frame 0x1C with busy observed mid-frame
    v0 = n_valid; e0 = n_err; q0 = rx.size();
    f = make_frame(8'h1C, 1'b1, 1'b1);
    send_bits(f, 0, 0);
    check("busy_after_start", 32'(busy), 32'h1);
    send_bits(f, 1, 10);
    ps2_data = 1'b1;
    wait_cyc(HALF);
    check("1c_valid_cnt", 32'(n_valid - v0), 32'd1);
    check("1c_err_cnt", 32'(n_err - e0), 32'd0);
    check("1c_rx", rx_at(q0), 32'h1C);
    check("1c_data", 32'(data), 32'h1C);
    check("1c_busy_low", 32'(busy), 32'h0);

    // Back-to-back 0xE0, 0x75
    v0 = n_valid; q0 = rx.size();
    send_frame(make_frame(8'hE0, 1'b1, 1'b1));
    send_frame(make_frame(8'h75, 1'b1, 1'b1));
    wait_cyc(HALF);
    check("b2b_valid_cnt", 32'(n_valid - v0), 32'd2);
    check("b2b_first", rx_at(q0), 32'hE0);
    check("b2b_second", rx_at(q0 + 1), 32'h75);

    // Parity error, then good 0xF0
    v0 = n_valid; e0 = n_err;
    send_frame(make_frame(8'h1C, 1'b0, 1'b1));
    wait_cyc(HALF);
    check("par_err_cnt", 32'(n_err - e0), 32'd1);
    check("par_valid_cnt", 32'(n_valid - v0), 32'd0);
    check("par_data_held", 32'(data), 32'h75);
    q0 = rx.size();
    send_frame(make_frame(8'hF0, 1'b1, 1'b1));
    wait_cyc(HALF);
    check("f0_rx", rx_at(q0), 32'hF0);
    check("f0_data", 32'(data), 32'hF0);

    // Stop-bit error
    v0 = n_valid; e0 = n_err;
    send_frame(make_frame(8'h29, 1'b1, 1'b0));
    wait_cyc(HALF);
    check("stop_err_cnt", 32'(n_err - e0), 32'd1);
    check("stop_valid_cnt", 32'(n_valid - v0), 32'd0);
    check("stop_data_held", 32'(data), 32'hF0);

    // Timeout after start + 4 data bits, then good 0x5A
    v0 = n_valid; e0 = n_err;
    send_bits(make_frame(8'h5A, 1'b1, 1'b1), 0, 4);
    ps2_data = 1'b1;
    check("to_busy_before", 32'(busy), 32'h1);
    wait_cyc(int'(TIMEOUT) + 50);
    check("to_err_cnt", 32'(n_err - e0), 32'd1);
    check("to_valid_cnt", 32'(n_valid - v0), 32'd0);
    check("to_busy_after", 32'(busy), 32'h0);
    q0 = rx.size();
    send_frame(make_frame(8'h5A, 1'b1, 1'b1));
    wait_cyc(HALF);
    check("5a_rx", rx_at(q0), 32'h5A);
    check("5a_data", 32'(data), 32'h5A);

    // Short low glitch on ps2_clk with data low in IDLE
    v0 = n_valid; e0 = n_err; busy_seen = 1'b0;
    ps2_data = 1'b0;
    wait_cyc(10);
    ps2_clk = 1'b0;
    wait_cyc(FILTER_LEN - 2);
    ps2_clk = 1'b1;
    for (int i = 0; i < 40; i++) begin
      wait_cyc(1);
      if (busy) busy_seen = 1'b1;
    end
    ps2_data = 1'b1;
    check("glitch_busy", 32'(busy_seen), 32'h0);
    check("glitch_pulses", 32'((n_valid - v0) + (n_err - e0)), 32'd0);

    // Reset after bit 5, leftover edges, then clean 0x12
    f = make_frame(8'h12, 1'b1, 1'b1);
    send_bits(f, 0, 5);
    reset = 1'b1;
    #1;
    check("mid_rst_data", 32'(data), 32'h00);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_valid", 32'(valid), 32'h0);
    check("mid_rst_error", 32'(error), 32'h0);
    wait_cyc(3);
    reset = 1'b0;
    v0 = n_valid; e0 = n_err;
    send_bits(f, 6, 10);
    ps2_data = 1'b1;
    wait_cyc(int'(TIMEOUT) + 50);
    check("leftover_valid", 32'(n_valid - v0), 32'd0);
    check("leftover_err", 32'(n_err - e0), 32'd1);
    q0 = rx.size();
    send_frame(f);
    wait_cyc(HALF);
    check("12_rx", rx_at(q0), 32'h12);
    check("12_data", 32'(data), 32'h12);

    check("valid_error_overlap", 32'(n_both), 32'd0);
    check("busy_at_valid", 32'(n_busy_at_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
